pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32IM pipeline.
- Drives the hold and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Arbitrates between these stall sources:
  - data-memory busywait
  - instruction-memory busywait
  - multi-cycle MUL/DIV occupancy of EX
  - load-use hazards
  - taken branch/jump redirects
- Also keeps saturating stall and flush performance counters.

Parameters:
MULDIV_LATENCY, 4, cycles the MUL/DIV unit occupies EX (≥1; 1 = no stall)
CNT_WIDTH, 16, width of performance counters

Ports:
CLK  input  1  clock, all state on posedge
RESET  input  1  synchronous active-low reset
D_MEM_BUSYWAIT  input  1  data memory not ready
I_MEM_BUSYWAIT  input  1  instruction memory not ready
BRANCH_TAKEN  input  1  EX-stage redirect (branch taken / JAL / JALR)
EX_IS_MULDIV  input  1  instruction in EX (ID/EX output) is M-extension
EX_MEM_READ  input  1  instruction in EX is a load
EX_RD  input  5  destination register of instruction in EX
ID_RS1  input  5  rs1 of instruction in ID
ID_RS2  input  5  rs2 of instruction in ID
ID_USES_RS1  input  1  ID instruction reads rs1
ID_USES_RS2  input  1  ID instruction reads rs2
PC_HOLD  output  1  PC keeps value
IF_ID_HOLD  output  1  IF/ID keeps value
ID_EX_HOLD  output  1  ID/EX keeps value
EX_MEM_HOLD  output  1  EX/MEM keeps value
MEM_WB_HOLD  output  1  MEM/WB keeps value
IF_ID_FLUSH  output  1  IF/ID loads bubble
ID_EX_FLUSH  output  1  ID/EX loads bubble
EX_MEM_FLUSH  output  1  EX/MEM loads bubble
STALL_COUNT  output  CNT_WIDTH  cycles with PC_HOLD=1
FLUSH_COUNT  output  CNT_WIDTH  number of branch redirects accepted

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-low.
- Output timing: hold/flush outputs are combinational from state and inputs. State and counters are registered.
- Reset (RESET=0 at posedge):
  - state ← RUN, down-counter ← 0, STALL_COUNT ← 0, FLUSH_COUNT ← 0.
  - While RESET=0: all HOLD=0, all FLUSH=1.
- State machine: RUN, MD_BUSY, MD_DONE.
- Priority, highest first:
  1. Reset.
  2. D_MEM_BUSYWAIT=1: all five HOLD=1, all FLUSH=0. The FSM keeps counting (see below).
  3. MD_BUSY, or MD_DONE with D_MEM_BUSYWAIT=0 (MD_DONE is released in this case):
     - PC_HOLD=IF_ID_HOLD=ID_EX_HOLD=1.
     - EX_MEM_FLUSH=1 while in MD_BUSY.
     - In MD_DONE with no busywait: EX_MEM_FLUSH=0, all HOLD=0, next state RUN.
  4. BRANCH_TAKEN=1 in RUN: IF_ID_FLUSH=ID_EX_FLUSH=1, PC_HOLD=0 even if I_MEM_BUSYWAIT=1. FLUSH_COUNT increments.
  5. Load-use: EX_MEM_READ & EX_RD≠0 & ((ID_USES_RS1 & ID_RS1==EX_RD) | (ID_USES_RS2 & ID_RS2==EX_RD)).
     - Response: PC_HOLD=IF_ID_HOLD=1, ID_EX_FLUSH=1. Exactly one cycle, no state.
  6. I_MEM_BUSYWAIT=1: PC_HOLD=1, IF_ID_FLUSH=1. Downstream stages advance.
  7. Otherwise all HOLD/FLUSH=0.
- MUL/DIV sequencing:
  - Entry: in RUN with EX_IS_MULDIV=1 and MULDIV_LATENCY>1, the FSM enters MD_BUSY at the next posedge with counter=MULDIV_LATENCY-2. The entry cycle itself already stalls: PC/IF_ID/ID_EX hold, EX_MEM flush.
  - Counting: MD_BUSY decrements every cycle regardless of D_MEM_BUSYWAIT.
  - At counter=0:
    - D_MEM_BUSYWAIT=0 → next RUN. The final MD_BUSY cycle releases EX_MEM (EX_MEM_FLUSH=0), so the result is captured.
    - D_MEM_BUSYWAIT=1 → MD_DONE. Wait there until busywait clears, then release as in priority 3.
  - Total EX occupancy is exactly MULDIV_LATENCY cycles when memory is idle.
  - Entry ignored while D_MEM_BUSYWAIT=1. It is re-evaluated when busywait drops, since EX is frozen.
- Simultaneous events:
  - Branch and load-use together: branch wins, no hold.
  - Branch during D_MEM_BUSYWAIT: no flush, no count. BRANCH_TAKEN persists because EX is frozen, and is taken when busywait clears.
- Counters:
  - STALL_COUNT increments when PC_HOLD=1 and RESET=1. FLUSH_COUNT increments as in priority 4.
  - Both saturate at all-ones with no wrap.
- Reset mid-operation: reset in MD_BUSY/MD_DONE returns to RUN immediately. The MUL/DIV result is discarded by the flush.

Decomposition:
- Shared package holds:
  - FSM state encoding (RUN=2'd0, MD_BUSY=2'd1, MD_DONE=2'd2)
  - register-number width constant (5)
  - x0 constant
- One sub-module: hazard_sat_counter (CNT_WIDTH, increment enable, sync active-low clear, saturation), instantiated twice.

Test Plan:
- RESET=0 for 2 cycles, then 1 → all FLUSH=1 during reset. After release all outputs 0, both counters 0.
- Load x5 in EX (EX_MEM_READ=1, EX_RD=5), ID_RS2=5, ID_USES_RS2=1:
  - that cycle: PC_HOLD=IF_ID_HOLD=ID_EX_FLUSH=1
  - next cycle: all clear
  - STALL_COUNT=1
- Same as above with EX_RD=0 → no stall.
- EX_IS_MULDIV=1, MULDIV_LATENCY=4, memory idle → PC_HOLD high exactly 3 cycles, EX_MEM_FLUSH high 3 cycles, RUN on cycle 4.
- MUL/DIV with D_MEM_BUSYWAIT=1 spanning the counter expiry:
  - FSM sits in MD_DONE with all holds high
  - releases one cycle after busywait falls
- BRANCH_TAKEN=1 with I_MEM_BUSYWAIT=1 and a load-use hit in the same cycle → IF_ID_FLUSH=ID_EX_FLUSH=1, PC_HOLD=0, FLUSH_COUNT=1.
- Hold D_MEM_BUSYWAIT=1 for 2^CNT_WIDTH+3 cycles → STALL_COUNT saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents:
//   - MUL/DIV sequencing state encoding
//   - Register-number width and the x0 constant
//   - Load-use hazard detection helper
package pipeline_hazard_controller_pkg;

    // MUL/DIV sequencing states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_MD_DONE = 2'd2
    } hz_state_e;

    localparam int                REG_W  = 5;
    localparam logic [REG_W-1:0]  REG_X0 = 5'd0;

    // A load in EX feeds a register that the ID instruction actually reads.
    // x0 is never a real dependency because writes to it are discarded.
    function automatic logic load_use_hit(
        input logic             mem_read,
        input logic [REG_W-1:0] ex_rd,
        input logic [REG_W-1:0] id_rs1,
        input logic [REG_W-1:0] id_rs2,
        input logic             uses_rs1,
        input logic             uses_rs2
    );
        logic rs1_dep;
        logic rs2_dep;
        rs1_dep = uses_rs1 & (id_rs1 == ex_rd);
        rs2_dep = uses_rs2 & (id_rs2 == ex_rd);
        return mem_read & (ex_rd != REG_X0) & (rs1_dep | rs2_dep);
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating event counter used for the stall/flush performance counters.
// Ports:
//   clk_i   - clock, state updates on posedge
//   clr_ni  - synchronous active-low clear
//   inc_i   - increment enable
//   count_o - current count, sticks at all-ones
module hazard_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 clr_ni,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next count: clear first, then increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (!clr_ni) begin
            count_d = CNT_ZERO;
        end else if (inc_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage RV32IM pipeline.
// Inputs : CLK, RESET (sync, active-low), D/I memory busywaits, EX-stage
//          redirect, MUL/DIV and load info of the EX instruction, source
//          registers of the ID instruction.
// Outputs: hold controls for PC and all four pipeline registers, bubble
//          controls for IF/ID, ID/EX, EX/MEM, and saturating stall/flush
//          performance counters.
// Hold/flush outputs are combinational from state and inputs; the MUL/DIV
// sequencer state and the counters are registered.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 D_MEM_BUSYWAIT,
    input  logic                 I_MEM_BUSYWAIT,
    input  logic                 BRANCH_TAKEN,
    input  logic                 EX_IS_MULDIV,
    input  logic                 EX_MEM_READ,
    input  logic [REG_W-1:0]     EX_RD,
    input  logic [REG_W-1:0]     ID_RS1,
    input  logic [REG_W-1:0]     ID_RS2,
    input  logic                 ID_USES_RS1,
    input  logic                 ID_USES_RS2,
    output logic                 PC_HOLD,
    output logic                 IF_ID_HOLD,
    output logic                 ID_EX_HOLD,
    output logic                 EX_MEM_HOLD,
    output logic                 MEM_WB_HOLD,
    output logic                 IF_ID_FLUSH,
    output logic                 ID_EX_FLUSH,
    output logic                 EX_MEM_FLUSH,
    output logic [CNT_WIDTH-1:0] STALL_COUNT,
    output logic [CNT_WIDTH-1:0] FLUSH_COUNT
);

    // The down-counter is loaded with LATENCY-2: the entry cycle and the
    // final release cycle are both part of the EX occupancy.
    localparam int               MD_CW     = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY - 1) : 1;
    localparam logic [MD_CW-1:0] MD_ZERO   = {MD_CW{1'b0}};
    localparam logic [MD_CW-1:0] MD_ONE    = MD_CW'(1);
    localparam logic [MD_CW-1:0] MD_LOAD   = MD_CW'((MULDIV_LATENCY > 1) ? (MULDIV_LATENCY - 2) : 0);
    localparam logic             MD_STALLS = (MULDIV_LATENCY > 1) ? 1'b1 : 1'b0;

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [MD_CW-1:0] md_cnt_q;
    logic [MD_CW-1:0] md_cnt_d;

    logic pc_hold_s;
    logic if_id_hold_s;
    logic id_ex_hold_s;
    logic ex_mem_hold_s;
    logic mem_wb_hold_s;
    logic if_id_flush_s;
    logic id_ex_flush_s;
    logic ex_mem_flush_s;
    logic flush_inc_s;
    logic load_use_s;
    logic md_entry_s;

    assign load_use_s = load_use_hit(EX_MEM_READ, EX_RD, ID_RS1, ID_RS2,
                                     ID_USES_RS1, ID_USES_RS2);
    assign md_entry_s = EX_IS_MULDIV & MD_STALLS;

    // Priority arbitration of stall sources and MUL/DIV next-state logic
    always_comb begin
        pc_hold_s      = 1'b0;
        if_id_hold_s   = 1'b0;
        id_ex_hold_s   = 1'b0;
        ex_mem_hold_s  = 1'b0;
        mem_wb_hold_s  = 1'b0;
        if_id_flush_s  = 1'b0;
        id_ex_flush_s  = 1'b0;
        ex_mem_flush_s = 1'b0;
        flush_inc_s    = 1'b0;
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;

        if (!RESET) begin
            // Bubble everything while in reset; the register resets separately.
            if_id_flush_s  = 1'b1;
            id_ex_flush_s  = 1'b1;
            ex_mem_flush_s = 1'b1;
            state_d        = ST_RUN;
            md_cnt_d       = MD_ZERO;
        end else if (D_MEM_BUSYWAIT) begin
            // Whole pipe frozen. The MUL/DIV unit keeps computing, so the
            // counter still runs; an expiry here parks in MD_DONE.
            pc_hold_s     = 1'b1;
            if_id_hold_s  = 1'b1;
            id_ex_hold_s  = 1'b1;
            ex_mem_hold_s = 1'b1;
            mem_wb_hold_s = 1'b1;
            case (state_q)
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_MD_BUSY: begin
                    if (md_cnt_q == MD_ZERO) begin
                        state_d = ST_MD_DONE;
                    end else begin
                        md_cnt_d = md_cnt_q - MD_ONE;
                    end
                end
                ST_MD_DONE: begin
                    state_d = ST_MD_DONE;
                end
                default: begin
                    state_d  = ST_RUN;
                    md_cnt_d = MD_ZERO;
                end
            endcase
        end else begin
            case (state_q)
                ST_MD_BUSY: begin
                    if (md_cnt_q == MD_ZERO) begin
                        // Result ready: let EX/MEM capture it and the pipe move.
                        state_d = ST_RUN;
                    end else begin
                        pc_hold_s      = 1'b1;
                        if_id_hold_s   = 1'b1;
                        id_ex_hold_s   = 1'b1;
                        ex_mem_flush_s = 1'b1;
                        md_cnt_d       = md_cnt_q - MD_ONE;
                    end
                end
                ST_MD_DONE: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (md_entry_s) begin
                        // The entry cycle is already the first stall cycle.
                        pc_hold_s      = 1'b1;
                        if_id_hold_s   = 1'b1;
                        id_ex_hold_s   = 1'b1;
                        ex_mem_flush_s = 1'b1;
                        state_d        = ST_MD_BUSY;
                        md_cnt_d       = MD_LOAD;
                    end else if (BRANCH_TAKEN) begin
                        // PC must load the redirect target even if fetch is busy.
                        if_id_flush_s = 1'b1;
                        id_ex_flush_s = 1'b1;
                        flush_inc_s   = 1'b1;
                    end else if (load_use_s) begin
                        pc_hold_s     = 1'b1;
                        if_id_hold_s  = 1'b1;
                        id_ex_flush_s = 1'b1;
                    end else if (I_MEM_BUSYWAIT) begin
                        pc_hold_s     = 1'b1;
                        if_id_flush_s = 1'b1;
                    end else begin
                        pc_hold_s = 1'b0;
                    end
                end
                default: begin
                    state_d  = ST_RUN;
                    md_cnt_d = MD_ZERO;
                end
            endcase
        end
    end

    // Sequencer state and MUL/DIV down-counter
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= ST_RUN;
            md_cnt_q <= MD_ZERO;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign PC_HOLD      = pc_hold_s;
    assign IF_ID_HOLD   = if_id_hold_s;
    assign ID_EX_HOLD   = id_ex_hold_s;
    assign EX_MEM_HOLD  = ex_mem_hold_s;
    assign MEM_WB_HOLD  = mem_wb_hold_s;
    assign IF_ID_FLUSH  = if_id_flush_s;
    assign ID_EX_FLUSH  = id_ex_flush_s;
    assign EX_MEM_FLUSH = ex_mem_flush_s;

    hazard_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk_i   (CLK),
        .clr_ni  (RESET),
        .inc_i   (pc_hold_s & RESET),
        .count_o (STALL_COUNT)
    );

    hazard_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk_i   (CLK),
        .clr_ni  (RESET),
        .inc_i   (flush_inc_s),
        .count_o (FLUSH_COUNT)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller with a behavioural
// model that tracks the multiply/divide as "EX cycles still to run".
module tb_pipeline_hazard_controller;

    localparam int LAT     = 4;
    localparam int CW      = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK;
    logic          RESET;
    logic          D_MEM_BUSYWAIT;
    logic          I_MEM_BUSYWAIT;
    logic          BRANCH_TAKEN;
    logic          EX_IS_MULDIV;
    logic          EX_MEM_READ;
    logic [4:0]    EX_RD;
    logic [4:0]    ID_RS1;
    logic [4:0]    ID_RS2;
    logic          ID_USES_RS1;
    logic          ID_USES_RS2;
    logic          PC_HOLD;
    logic          IF_ID_HOLD;
    logic          ID_EX_HOLD;
    logic          EX_MEM_HOLD;
    logic          MEM_WB_HOLD;
    logic          IF_ID_FLUSH;
    logic          ID_EX_FLUSH;
    logic          EX_MEM_FLUSH;
    logic [CW-1:0] STALL_COUNT;
    logic [CW-1:0] FLUSH_COUNT;

    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB holds, IF_ID, ID_EX, EX_MEM flushes}
    logic [7:0] ctl;
    assign ctl = {PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD,
                  IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH};

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_md_active = 1'b0;
    int m_md_left   = 0;
    int m_stall     = 0;
    int m_flush     = 0;

    pipeline_hazard_controller #(
        .MULDIV_LATENCY (LAT),
        .CNT_WIDTH      (CW)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .D_MEM_BUSYWAIT (D_MEM_BUSYWAIT),
        .I_MEM_BUSYWAIT (I_MEM_BUSYWAIT),
        .BRANCH_TAKEN   (BRANCH_TAKEN),
        .EX_IS_MULDIV   (EX_IS_MULDIV),
        .EX_MEM_READ    (EX_MEM_READ),
        .EX_RD          (EX_RD),
        .ID_RS1         (ID_RS1),
        .ID_RS2         (ID_RS2),
        .ID_USES_RS1    (ID_USES_RS1),
        .ID_USES_RS2    (ID_USES_RS2),
        .PC_HOLD        (PC_HOLD),
        .IF_ID_HOLD     (IF_ID_HOLD),
        .ID_EX_HOLD     (ID_EX_HOLD),
        .EX_MEM_HOLD    (EX_MEM_HOLD),
        .MEM_WB_HOLD    (MEM_WB_HOLD),
        .IF_ID_FLUSH    (IF_ID_FLUSH),
        .ID_EX_FLUSH    (ID_EX_FLUSH),
        .EX_MEM_FLUSH   (EX_MEM_FLUSH),
        .STALL_COUNT    (STALL_COUNT),
        .FLUSH_COUNT    (FLUSH_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit m_load_use();
        return EX_MEM_READ && (EX_RD != 5'd0) &&
               ((ID_USES_RS1 && (ID_RS1 == EX_RD)) || (ID_USES_RS2 && (ID_RS2 == EX_RD)));
    endfunction

    function automatic bit m_md_start();
        return !m_md_active && EX_IS_MULDIV && (LAT > 1);
    endfunction

    function automatic logic [7:0] model_ctl();
        if (!RESET)                       return 8'b00000_111;
        if (D_MEM_BUSYWAIT)               return 8'b11111_000;
        if (m_md_active && m_md_left <= 1) return 8'b00000_000;
        if (m_md_active || m_md_start())  return 8'b11100_001;
        if (BRANCH_TAKEN)                 return 8'b00000_110;
        if (m_load_use())                 return 8'b11000_010;
        if (I_MEM_BUSYWAIT)               return 8'b10000_100;
        return 8'b00000_000;
    endfunction

    task automatic model_update();
        logic [7:0] e;
        e = model_ctl();
        if (!RESET) begin
            m_md_active = 1'b0;
            m_md_left   = 0;
            m_stall     = 0;
            m_flush     = 0;
        end else begin
            if (e[7] && m_stall < CNT_MAX) m_stall++;
            if (!D_MEM_BUSYWAIT && !m_md_active && !m_md_start() && BRANCH_TAKEN && m_flush < CNT_MAX)
                m_flush++;
            if (m_md_active) begin
                if (!D_MEM_BUSYWAIT && m_md_left <= 1) m_md_active = 1'b0;
                else if (m_md_left > 0)                m_md_left--;
            end else if (!D_MEM_BUSYWAIT && m_md_start()) begin
                m_md_active = 1'b1;
                m_md_left   = LAT - 1;
            end
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        D_MEM_BUSYWAIT = 1'b0; I_MEM_BUSYWAIT = 1'b0; BRANCH_TAKEN = 1'b0;
        EX_IS_MULDIV = 1'b0;   EX_MEM_READ = 1'b0;    EX_RD = 5'd0;
        ID_RS1 = 5'd0; ID_RS2 = 5'd0; ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        RESET = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (ctl !== 8'b00000_111) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 8'b00000_111); end
            tick();
        end
        RESET = 1'b1;
        @(negedge CLK);
        checks += 3;
        if (ctl !== 8'd0) begin errors++; $display("FAIL post_reset_ctl: got %b expected %b", ctl, 8'd0); end
        if (STALL_COUNT !== 16'd0) begin errors++; $display("FAIL post_reset_stall: got %0d expected 0", STALL_COUNT); end
        if (FLUSH_COUNT !== 16'd0) begin errors++; $display("FAIL post_reset_flush: got %0d expected 0", FLUSH_COUNT); end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        EX_MEM_READ = 1'b1; EX_RD = 5'd5; ID_RS2 = 5'd5; ID_USES_RS2 = 1'b1; ID_RS1 = 5'd7; ID_USES_RS1 = 1'b1;
        @(negedge CLK);
        checks++;
        if (ctl !== 8'b11000_010) begin errors++; $display("FAIL load_use_ctl: got %b expected %b", ctl, 8'b11000_010); end
        tick();
        idle_inputs();
        @(negedge CLK);
        checks += 2;
        if (ctl !== 8'd0) begin errors++; $display("FAIL load_use_after: got %b expected %b", ctl, 8'd0); end
        if (STALL_COUNT !== 16'd1) begin errors++; $display("FAIL load_use_stall_cnt: got %0d expected 1", STALL_COUNT); end
        tick();
    endtask

    task automatic test_load_use_x0();
        EX_MEM_READ = 1'b1; EX_RD = 5'd0; ID_RS2 = 5'd0; ID_USES_RS2 = 1'b1;
        @(negedge CLK);
        checks++;
        if (ctl !== 8'd0) begin errors++; $display("FAIL load_x0_ctl: got %b expected %b", ctl, 8'd0); end
        tick();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (STALL_COUNT !== 16'd1) begin errors++; $display("FAIL load_x0_stall_cnt: got %0d expected 1", STALL_COUNT); end
    endtask

    task automatic test_muldiv();
        int pc_cycles = 0;
        int fl_cycles = 0;
        logic [7:0] e;
        do_reset();
        EX_IS_MULDIV = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge CLK);
            e = model_ctl();
            checks++;
            if (ctl !== e) begin errors++; $display("FAIL muldiv_cyc%0d: got %b expected %b", i, ctl, e); end
            if (PC_HOLD) pc_cycles++;
            if (EX_MEM_FLUSH) fl_cycles++;
            tick();
        end
        EX_IS_MULDIV = 1'b0;
        @(negedge CLK);
        checks += 3;
        if (pc_cycles != LAT - 1) begin errors++; $display("FAIL muldiv_pc_hold_len: got %0d expected %0d", pc_cycles, LAT - 1); end
        if (fl_cycles != LAT - 1) begin errors++; $display("FAIL muldiv_flush_len: got %0d expected %0d", fl_cycles, LAT - 1); end
        if (ctl !== 8'd0) begin errors++; $display("FAIL muldiv_run_after: got %b expected %b", ctl, 8'd0); end
        tick();
    endtask

    task automatic test_muldiv_dmem();
        // entry, then busywait over the counter expiry, then release
        logic [6:0] dmem_seq;
        logic [7:0] e;
        dmem_seq = 7'b0011110;
        do_reset();
        EX_IS_MULDIV = 1'b1;
        for (int i = 0; i < 7; i++) begin
            D_MEM_BUSYWAIT = dmem_seq[i];
            if (i == 6) EX_IS_MULDIV = 1'b0;
            @(negedge CLK);
            e = model_ctl();
            checks++;
            if (ctl !== e) begin errors++; $display("FAIL md_dmem_cyc%0d: got %b expected %b", i, ctl, e); end
            if (i == 4) begin
                checks++;
                if (ctl !== 8'b11111_000) begin errors++; $display("FAIL md_done_hold: got %b expected %b", ctl, 8'b11111_000); end
            end
            if (i == 5) begin
                checks++;
                if (ctl !== 8'd0) begin errors++; $display("FAIL md_done_release: got %b expected %b", ctl, 8'd0); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_branch_combo();
        do_reset();
        BRANCH_TAKEN = 1'b1; I_MEM_BUSYWAIT = 1'b1;
        EX_MEM_READ = 1'b1; EX_RD = 5'd9; ID_RS1 = 5'd9; ID_USES_RS1 = 1'b1;
        @(negedge CLK);
        checks++;
        if (ctl !== 8'b00000_110) begin errors++; $display("FAIL branch_combo_ctl: got %b expected %b", ctl, 8'b00000_110); end
        tick();
        idle_inputs();
        @(negedge CLK);
        checks += 2;
        if (FLUSH_COUNT !== 16'd1) begin errors++; $display("FAIL branch_flush_cnt: got %0d expected 1", FLUSH_COUNT); end
        if (STALL_COUNT !== 16'd0) begin errors++; $display("FAIL branch_stall_cnt: got %0d expected 0", STALL_COUNT); end
    endtask

    task automatic test_branch_dmem();
        BRANCH_TAKEN = 1'b1; D_MEM_BUSYWAIT = 1'b1;
        @(negedge CLK);
        checks++;
        if (ctl !== 8'b11111_000) begin errors++; $display("FAIL branch_dmem_ctl: got %b expected %b", ctl, 8'b11111_000); end
        tick();
        D_MEM_BUSYWAIT = 1'b0;
        @(negedge CLK);
        checks += 2;
        if (FLUSH_COUNT !== 16'd1) begin errors++; $display("FAIL branch_dmem_nocount: got %0d expected 1", FLUSH_COUNT); end
        if (ctl !== 8'b00000_110) begin errors++; $display("FAIL branch_after_dmem: got %b expected %b", ctl, 8'b00000_110); end
        tick();
        idle_inputs();
        @(negedge CLK);
        checks++;
        if (FLUSH_COUNT !== 16'd2) begin errors++; $display("FAIL branch_late_count: got %0d expected 2", FLUSH_COUNT); end
    endtask

    task automatic test_random();
        int kind;
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            kind           = int'($urandom_range(0, 3));
            RESET          = ($urandom_range(0, 63) != 0);
            D_MEM_BUSYWAIT = ($urandom_range(0, 3) == 0);
            I_MEM_BUSYWAIT = ($urandom_range(0, 3) == 0);
            BRANCH_TAKEN   = (kind == 1);
            EX_IS_MULDIV   = (kind == 2);
            EX_MEM_READ    = (kind == 3);
            EX_RD          = 5'($urandom_range(0, 3));
            ID_RS1         = 5'($urandom_range(0, 3));
            ID_RS2         = 5'($urandom_range(0, 3));
            ID_USES_RS1    = 1'($urandom_range(0, 1));
            ID_USES_RS2    = 1'($urandom_range(0, 1));
            @(negedge CLK);
            e = model_ctl();
            checks += 3;
            if (ctl !== e) begin errors++; $display("FAIL rand_ctl[%0d]: got %b expected %b", i, ctl, e); end
            if (STALL_COUNT !== CW'(m_stall)) begin errors++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", i, STALL_COUNT, m_stall); end
            if (FLUSH_COUNT !== CW'(m_flush)) begin errors++; $display("FAIL rand_flush[%0d]: got %0d expected %0d", i, FLUSH_COUNT, m_flush); end
            tick();
        end
        RESET = 1'b1;
        idle_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        D_MEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < CNT_MAX; i++) tick();
        @(negedge CLK);
        checks++;
        if (STALL_COUNT !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", STALL_COUNT); end
        for (int i = 0; i < 4; i++) tick();
        @(negedge CLK);
        checks += 2;
        if (STALL_COUNT !== 16'hFFFF) begin errors++; $display("FAIL sat_nowrap: got %h expected ffff", STALL_COUNT); end
        if (STALL_COUNT !== CW'(m_stall)) begin errors++; $display("FAIL sat_model: got %h expected %h", STALL_COUNT, m_stall); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        RESET = 1'b0;
        test_reset();
        test_load_use();
        test_load_use_x0();
        test_muldiv();
        test_muldiv_dmem();
        test_branch_combo();
        test_branch_dmem();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
